// File: rtl/adder_tree_sched.sv
// Round-robin share of one pipelined adder tree among NUM_REQ requesters; optional ADDER_TREE_SCHED_ACCUM_EN row accumulators.
// Response no earlier than 2+TREE_LAT cycles after accept; grants stop while FIFO plus in-flight batches fill FIFO_DEPTH.
module adder_tree_sched #(
  parameter int NUM_TOT_ELEMENT    = 8,
  parameter int RANK_FACTOR_MATRIX = 16,
  parameter int N                  = 32,
  parameter int NUM_REQ            = 4,
  parameter int TREE_LAT           = 3,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [NUM_REQ-1:0]                                      req_valid,
  input  logic [NUM_REQ-1:0]                                      req_last,
  input  logic [NUM_REQ*NUM_TOT_ELEMENT*RANK_FACTOR_MATRIX*N-1:0] req_data,
  output logic [NUM_REQ-1:0]                                      req_ready,
  output logic                                                    tree_in_avl,
  output logic [NUM_TOT_ELEMENT*RANK_FACTOR_MATRIX*N-1:0]         tree_inputs,
  input  logic                                                    tree_out_avl,
  input  logic [RANK_FACTOR_MATRIX*N-1:0]                         tree_c,
  output logic                                                    rsp_valid,
  input  logic                                                    rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]                              rsp_id,
  output logic                                                    rsp_last,
  output logic [RANK_FACTOR_MATRIX*N-1:0]                         rsp_data,
  output logic                                                    err
);
  localparam int VW  = RANK_FACTOR_MATRIX * N;
  localparam int BW  = NUM_TOT_ELEMENT * VW;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(FIFO_DEPTH + TREE_LAT + 2);

  logic [IDW-1:0]      rr;
  logic [IDW-1:0]      win_id;
  logic                win_found;
  logic                accept;
  logic                credit_ok;
  logic [OW-1:0]       occ;
  logic [IDW-1:0]      iss_id;
  logic                iss_last;
  logic [TREE_LAT-1:0] tag_vld;
  logic [TREE_LAT-1:0] tag_last;
  logic [IDW-1:0]      tag_id [TREE_LAT];
  logic                head_vld;
  logic                head_last;
  logic [IDW-1:0]      head_id;
  logic [VW-1:0]       fifo_dat [FIFO_DEPTH];
  logic [IDW-1:0]      fifo_id [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_cnt;
  logic                push;
  logic                pop;
  logic                push_last;
  logic [VW-1:0]       push_dat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The issue register counts as the first in-flight stage so a batch is covered from the cycle after its grant.
  always_comb begin
    occ = OW'(fifo_cnt) + OW'(tree_in_avl);
    for (int k = 0; k < TREE_LAT; k++) begin
      occ = occ + OW'(tag_vld[k]);
    end
  end

  assign credit_ok = (occ < OW'(FIFO_DEPTH));

  always_comb begin
    int j;
    win_found = 1'b0;
    win_id    = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_id    = IDW'(j);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && credit_ok && win_found) req_ready[win_id] = 1'b1;
  end

  assign accept    = |(req_valid & req_ready);
  assign head_vld  = tag_vld[TREE_LAT-1];
  assign head_last = tag_last[TREE_LAT-1];
  assign head_id   = tag_id[TREE_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr          <= '0;
      tree_in_avl <= 1'b0;
      tree_inputs <= '0;
      iss_id      <= '0;
      iss_last    <= 1'b0;
      tag_vld     <= '0;
      tag_last    <= '0;
      for (int k = 0; k < TREE_LAT; k++) tag_id[k] <= '0;
      err         <= 1'b0;
    end else begin
      tree_in_avl <= accept;
      if (accept) begin
        tree_inputs <= req_data[int'(win_id)*BW +: BW];
        iss_id      <= win_id;
        iss_last    <= req_last[win_id];
        rr          <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end
      // Tag stage 0 samples alongside the tree, so the head lines up with out_avl.
      tag_vld[0]  <= tree_in_avl;
      tag_last[0] <= iss_last;
      tag_id[0]   <= iss_id;
      for (int k = 1; k < TREE_LAT; k++) begin
        tag_vld[k]  <= tag_vld[k-1];
        tag_last[k] <= tag_last[k-1];
        tag_id[k]   <= tag_id[k-1];
      end
      if (tree_out_avl ^ head_vld) err <= 1'b1;
    end
  end

`ifdef ADDER_TREE_SCHED_ACCUM_EN
  logic [VW-1:0] acc [NUM_REQ];
  logic [VW-1:0] acc_sum;

  always_comb begin
    acc_sum = '0;
    for (int l = 0; l < RANK_FACTOR_MATRIX; l++) begin
      acc_sum[l*N +: N] = acc[head_id][l*N +: N] + tree_c[l*N +: N];
    end
  end

  // Partial rows fold into the accumulator and free their credit without touching the FIFO.
  assign push      = tree_out_avl && head_vld && head_last;
  assign push_dat  = acc_sum;
  assign push_last = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REQ; r++) acc[r] <= '0;
    end else if (tree_out_avl && head_vld) begin
      acc[head_id] <= head_last ? '0 : acc_sum;
    end
  end
`else
  assign push      = tree_out_avl && head_vld;
  assign push_dat  = tree_c;
  assign push_last = head_last;
`endif

  assign pop = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat[wr_ptr]  <= push_dat;
      fifo_id[wr_ptr]   <= head_id;
      fifo_last[wr_ptr] <= push_last;
    end
  end

  // Outputs are forced to zero while empty so reset clears them without resetting the storage.
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_id    = rsp_valid ? fifo_id[rd_ptr]   : '0;
  assign rsp_last  = rsp_valid ? fifo_last[rd_ptr] : 1'b0;
  assign rsp_data  = rsp_valid ? fifo_dat[rd_ptr]  : '0;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Bench for adder_tree_sched: behavioural adder-tree model, grant/response monitor, queue-based reference.
module tb_adder_tree_sched;
  localparam int NE  = 8;
  localparam int RF  = 16;
  localparam int NB  = 32;
  localparam int NR  = 4;
  localparam int TL  = 3;
  localparam int FD  = 8;
  localparam int RW  = RF * NB;
  localparam int BW  = NE * RW;
  localparam int IDW = $clog2(NR);

  typedef struct {
    int          id;
    logic        last;
    logic [RW-1:0] sum;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_last = '0;
  logic [NR*BW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             tree_in_avl;
  logic [BW-1:0]    tree_inputs;
  logic             tree_out_avl;
  logic [RW-1:0]    tree_c;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IDW-1:0]   rsp_id;
  logic             rsp_last;
  logic [RW-1:0]    rsp_data;
  logic             err;
  logic             inj = 1'b0;
  logic             kill = 1'b0;

  int checks = 0;
  int errors = 0;
  rec_t grant_q[$];
  rec_t rsp_q[$];
  rec_t exp_q[$];

  always #5 clk = ~clk;

  adder_tree_sched #(
    .NUM_TOT_ELEMENT(NE), .RANK_FACTOR_MATRIX(RF), .N(NB),
    .NUM_REQ(NR), .TREE_LAT(TL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .tree_in_avl(tree_in_avl), .tree_inputs(tree_inputs),
    .tree_out_avl(tree_out_avl), .tree_c(tree_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_last(rsp_last), .rsp_data(rsp_data), .err(err)
  );

  function automatic logic [RW-1:0] ref_sum(input logic [BW-1:0] b);
    logic [RW-1:0] r;
    logic [NB-1:0] s;
    r = '0;
    for (int l = 0; l < RF; l++) begin
      s = '0;
      for (int e = 0; e < NE; e++) s = s + b[(e*RF+l)*NB +: NB];
      r[l*NB +: NB] = s;
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] lane_add(input logic [RW-1:0] a, input logic [RW-1:0] b);
    logic [RW-1:0] r;
    r = '0;
    for (int l = 0; l < RF; l++) r[l*NB +: NB] = a[l*NB +: NB] + b[l*NB +: NB];
    return r;
  endfunction

  // Environment: fixed-latency tree that cannot stall, reset by the same rst.
  logic [TL-1:0] tv;
  logic [RW-1:0] td [TL];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv <= '0;
      for (int k = 0; k < TL; k++) td[k] <= '0;
    end else begin
      tv[0] <= tree_in_avl;
      td[0] <= ref_sum(tree_inputs);
      for (int k = 1; k < TL; k++) begin
        tv[k] <= tv[k-1];
        td[k] <= td[k-1];
      end
    end
  end
  assign tree_out_avl = (tv[TL-1] & ~kill) | inj;
  assign tree_c       = td[TL-1];

  function automatic rec_t mk_grant();
    rec_t r;
    r.id = 0; r.last = 1'b0; r.sum = '0;
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        r.id = i; r.last = req_last[i]; r.sum = ref_sum(req_data[i*BW +: BW]);
      end
    end
    return r;
  endfunction

  function automatic rec_t mk_rsp();
    rec_t r;
    r.id = int'(rsp_id); r.last = rsp_last; r.sum = rsp_data;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (|(req_valid & req_ready)) grant_q.push_back(mk_grant());
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) rsp_q.push_back(mk_rsp());
    end
  end

  // Reference: responses follow grant order; with accumulation only row-closing batches respond.
  function automatic void build_exp();
`ifdef ADDER_TREE_SCHED_ACCUM_EN
    logic [RW-1:0] acc [NR];
    rec_t r;
    for (int i = 0; i < NR; i++) acc[i] = '0;
`endif
    exp_q.delete();
    foreach (grant_q[k]) begin
`ifdef ADDER_TREE_SCHED_ACCUM_EN
      if (grant_q[k].last) begin
        r.id = grant_q[k].id; r.last = 1'b1; r.sum = lane_add(acc[grant_q[k].id], grant_q[k].sum);
        exp_q.push_back(r);
        acc[grant_q[k].id] = '0;
      end else begin
        acc[grant_q[k].id] = lane_add(acc[grant_q[k].id], grant_q[k].sum);
      end
`else
      exp_q.push_back(grant_q[k]);
`endif
    end
  endfunction

  task automatic do_reset();
    req_valid = '0; req_last = '0; req_data = '0; rsp_ready = 1'b0; inj = 1'b0; kill = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    grant_q.delete(); rsp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fill(input int i, input logic [NB-1:0] v);
    for (int w = 0; w < NE*RF; w++) req_data[i*BW + w*NB +: NB] = v;
  endtask

  task automatic rand_data();
    for (int w = 0; w < NR*BW/32; w++) req_data[w*32 +: 32] = $urandom;
  endtask

  task automatic wait_rsp(input int n);
    for (int c = 0; c < 200 && rsp_q.size() < n; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'hf;
    #1 rst = 1'b0;
    #2;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (tree_in_avl !== 1'b0) begin errors++; $display("FAIL reset_in_avl: got %b want 0", tree_in_avl); end
    checks++; if (tree_inputs !== '0) begin errors++; $display("FAIL reset_tree_inputs: nonzero"); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_last !== 1'b0 || rsp_id !== '0) begin
      errors++; $display("FAIL reset_rsp: valid=%b id=%0d last=%b want all zero", rsp_valid, rsp_id, rsp_last); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    do_reset();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL reset_wrap_grant: got %b want 1000", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    int lat;
    logic [RW-1:0] e8;
    e8 = {RF{32'd8}};
    do_reset();
    req_valid = 4'b0100; req_last = 4'b0100; fill(2, 32'd1);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0; req_last = '0;
    #1;
    checks++; if (tree_in_avl !== 1'b1) begin errors++; $display("FAIL single_in_avl: got %b want 1", tree_in_avl); end
    checks++; if (tree_inputs !== req_data[2*BW +: BW]) begin errors++; $display("FAIL single_tree_inputs: batch not forwarded"); end
    lat = 0;
    for (int k = 2; k <= 20 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) lat = k;
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL single_latency: got %0d want 5", lat); end
    checks++; if (rsp_id !== 2'd2 || rsp_last !== 1'b1) begin errors++; $display("FAIL single_id_last: id=%0d last=%b want 2/1", rsp_id, rsp_last); end
    checks++; if (rsp_data !== e8) begin errors++; $display("FAIL single_data: got %h want %h", rsp_data, e8); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pop: rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_fairness();
    do_reset();
    rsp_ready = 1'b1; req_valid = 4'hf;
    for (int c = 0; c < 16; c++) begin
      rand_data(); req_last = 4'($urandom);
      #1;
      checks++; if ($countones(req_ready) != 1) begin errors++; $display("FAIL fair_onehot: cycle %0d req_ready=%b", c, req_ready); end
      @(posedge clk); #1;
    end
    req_valid = '0;
    checks++; if (grant_q.size() != 16) begin errors++; $display("FAIL fair_count: got %0d want 16", grant_q.size()); end
    foreach (grant_q[k]) begin
      checks++; if (grant_q[k].id != k % NR) begin errors++; $display("FAIL fair_order: grant %0d id=%0d want %0d", k, grant_q[k].id, k % NR); end
    end
    build_exp();
    wait_rsp(exp_q.size());
    checks++; if (rsp_q.size() != exp_q.size()) begin errors++; $display("FAIL fair_rsp_count: got %0d want %0d", rsp_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < rsp_q.size(); k++) begin
      checks++;
      if (rsp_q[k].id != exp_q[k].id || rsp_q[k].last !== exp_q[k].last || rsp_q[k].sum !== exp_q[k].sum) begin
        errors++; $display("FAIL fair_rsp: idx %0d id=%0d last=%b want id=%0d last=%b (data %s)", k, rsp_q[k].id, rsp_q[k].last,
                            exp_q[k].id, exp_q[k].last, (rsp_q[k].sum === exp_q[k].sum) ? "ok" : "differs");
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fair_err: got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'hf; req_last = 4'hf;
    for (int c = 0; c < 20; c++) begin
      rand_data();
      @(posedge clk); #1;
    end
    #1;
    checks++; if (grant_q.size() != FD) begin errors++; $display("FAIL bp_accepts: got %0d want %0d", grant_q.size(), FD); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_stall: req_ready=%b want 0000", req_ready); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_same_cycle: req_ready=%b want 0000", req_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    #1;
    checks++; if ($countones(req_ready) != 1) begin errors++; $display("FAIL bp_regrant: req_ready=%b want one-hot", req_ready); end
    @(posedge clk); #1;
    #1;
    checks++; if (req_ready !== '0 || grant_q.size() != FD + 1) begin
      errors++; $display("FAIL bp_one_more: req_ready=%b grants=%0d want 0000/%0d", req_ready, grant_q.size(), FD + 1); end
    req_valid = '0; rsp_ready = 1'b1;
    build_exp();
    wait_rsp(exp_q.size());
    checks++; if (rsp_q.size() != FD + 1) begin errors++; $display("FAIL bp_rsp_count: got %0d want %0d", rsp_q.size(), FD + 1); end
    for (int k = 0; k < exp_q.size() && k < rsp_q.size(); k++) begin
      checks++;
      if (rsp_q[k].id != exp_q[k].id || rsp_q[k].sum !== exp_q[k].sum) begin
        errors++; $display("FAIL bp_rsp: idx %0d id=%0d want %0d (data %s)", k, rsp_q[k].id, exp_q[k].id,
                            (rsp_q[k].sum === exp_q[k].sum) ? "ok" : "differs");
      end
    end
  endtask

  task automatic test_accum();
    int n_exp;
    logic [NB-1:0] lane_exp [4];
    logic last_exp [4];
    logic [NB-1:0] vals [4];
    logic [RW-1:0] want;
    vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3; vals[3] = 32'd5;
`ifdef ADDER_TREE_SCHED_ACCUM_EN
    n_exp = 2;
    lane_exp[0] = 32'd48; last_exp[0] = 1'b1;
    lane_exp[1] = 32'd40; last_exp[1] = 1'b1;
    lane_exp[2] = 32'd0;  last_exp[2] = 1'b0;
    lane_exp[3] = 32'd0;  last_exp[3] = 1'b0;
`else
    n_exp = 4;
    lane_exp[0] = 32'd8;  last_exp[0] = 1'b0;
    lane_exp[1] = 32'd16; last_exp[1] = 1'b0;
    lane_exp[2] = 32'd24; last_exp[2] = 1'b1;
    lane_exp[3] = 32'd40; last_exp[3] = 1'b1;
`endif
    do_reset();
    rsp_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      req_valid = 4'b0010;
      req_last  = (b >= 2) ? 4'b0010 : 4'b0000;
      fill(1, vals[b]);
      @(posedge clk); #1;
    end
    req_valid = '0; req_last = '0;
    wait_rsp(n_exp);
    checks++; if (rsp_q.size() != n_exp) begin errors++; $display("FAIL accum_count: got %0d want %0d", rsp_q.size(), n_exp); end
    for (int k = 0; k < n_exp && k < rsp_q.size(); k++) begin
      want = {RF{lane_exp[k]}};
      checks++;
      if (rsp_q[k].id != 1 || rsp_q[k].last !== last_exp[k] || rsp_q[k].sum !== want) begin
        errors++; $display("FAIL accum_rsp: idx %0d id=%0d last=%b lane0=%0d want id=1 last=%b lane0=%0d", k, rsp_q[k].id,
                            rsp_q[k].last, rsp_q[k].sum[NB-1:0], last_exp[k], lane_exp[k]);
      end
    end
  endtask

  task automatic test_error();
    do_reset();
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_spurious: err=%b want 1", err); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL err_discard: rsp_valid=%b want 0", rsp_valid); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b want 1", err); end
    rst = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b want 0", err); end
    do_reset();
    kill = 1'b1;
    req_valid = 4'b0001; req_last = 4'b0001; fill(0, 32'd7);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (err !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL err_missing_avl: err=%b rsp_valid=%b want 1/0", err, rsp_valid); end
    kill = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'hf; req_last = 4'hf;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_precond: rsp_valid=%b want 1", rsp_valid); end
    req_valid = 4'hf;
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || tree_in_avl !== 1'b0 || tree_inputs !== '0 || rsp_valid !== 1'b0 ||
        rsp_id !== '0 || rsp_last !== 1'b0 || rsp_data !== '0 || err !== 1'b0) begin
      errors++; $display("FAIL mid_outputs: ready=%b in_avl=%b valid=%b id=%0d last=%b err=%b want all zero",
                         req_ready, tree_in_avl, rsp_valid, rsp_id, rsp_last, err);
    end
    grant_q.delete(); rsp_q.delete();
    req_valid = 4'b1011;
    #1 rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_after: rsp_valid=%b want 0", rsp_valid); end
    @(posedge clk); #1;
    req_valid = '0; rsp_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checks++; if (grant_q.size() != 1 || rsp_q.size() != 1) begin
      errors++; $display("FAIL mid_flush: grants=%0d rsps=%0d want 1/1", grant_q.size(), rsp_q.size()); end
    if (rsp_q.size() > 0) begin
      checks++; if (rsp_q[0].id != 0) begin errors++; $display("FAIL mid_rsp_id: got %0d want 0", rsp_q[0].id); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_accum();
    test_error();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/adder_tree_sched.md
# adder_tree_sched

Round-robin scheduler that shares one pipelined `adder_tree` among `NUM_REQ` MTTKRP processing elements. Each element presents a batch of `NUM_TOT_ELEMENT` partial rank-vectors. The scheduler grants one batch per cycle and drives the tree inputs. It tracks in-flight batches with a tag pipeline matched to the tree latency. Returned sums are buffered in a credit-protected response FIFO and delivered to the output-merge stage with the originating requester ID.

## Interface
Parameters:
- `NUM_TOT_ELEMENT`, 8, vectors per batch (tree width)
- `RANK_FACTOR_MATRIX`, 16, lanes per vector
- `N`, 32, lane width in bits
- `NUM_REQ`, 4, number of requesters (≥2)
- `TREE_LAT`, 3, cycles from tree `in_avl` to `out_avl`; must equal log2(`NUM_TOT_ELEMENT`)
- `FIFO_DEPTH`, 8, response FIFO entries (≥`TREE_LAT`+1)

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `req_valid` in `NUM_REQ`: batch offered, one bit per requester
- `req_last` in `NUM_REQ`: batch closes the requester's current output row
- `req_data` in `NUM_REQ`×`NUM_TOT_ELEMENT`×`RANK_FACTOR_MATRIX`×`N`: batch payloads
- `req_ready` out `NUM_REQ`: one-hot grant; accept = `req_valid[i]` & `req_ready[i]`
- `tree_in_avl` out 1: drives tree `in_avl`
- `tree_inputs` out `NUM_TOT_ELEMENT`×`RANK_FACTOR_MATRIX`×`N`: drives tree `adder_inputs`
- `tree_out_avl` in 1: tree `out_avl`
- `tree_c` in `RANK_FACTOR_MATRIX`×`N`: tree result
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: consumer accepts
- `rsp_id` out clog2(`NUM_REQ`): originating requester
- `rsp_last` out 1: copy of the batch's `req_last`
- `rsp_data` out `RANK_FACTOR_MATRIX`×`N`: summed vector
- `err` out 1: sticky tag/avl mismatch flag

## Operation
- **Credit.** `occ` = FIFO occupancy + valid tag-pipe entries. A grant is allowed only when `occ` < `FIFO_DEPTH`. Because the tree cannot stall, this guarantees every result can be stored.
- **Arbitration.**
  - Round-robin pointer `rr` (reset 0).
  - Winner is the first `i` with `req_valid[i]`, searching `rr`, `rr+1`, … modulo `NUM_REQ`.
  - `req_ready` is combinational and one-hot on the winner, all-zero if there is no credit or no request.
  - On accept, `rr` ← winner+1, wrapping to 0. `rr` is unchanged when nothing is accepted.
- **Issue.** On accept, register `tree_inputs` ← `req_data[winner]` and `tree_in_avl` ← 1. Otherwise `tree_in_avl` ← 0 and `tree_inputs` holds its value.
- **Tag pipe.** A `TREE_LAT`-deep shift register of {valid, id, last} is loaded in step with `tree_in_avl`. The head is consumed when `tree_out_avl` is high.
- **Error.** `err` is set and held until reset when:
  - `tree_out_avl`=1 with the head invalid, or
  - the head is valid with `tree_out_avl`=0.
  
  When the head is invalid, the result is discarded.
- **Response FIFO.** `tree_out_avl` pushes {head id, head last, `tree_c`}. Pop occurs on `rsp_valid` & `rsp_ready`. Simultaneous push and pop in the same cycle leaves occupancy unchanged. The credit rule makes overflow unreachable. `rsp_*` reflect the FIFO head.
- **Reset.** Asynchronous, active-low. It clears `req_ready`, `tree_in_avl`, `tree_inputs`, `rsp_valid`, `rsp_id`, `rsp_last`, `rsp_data`, `err`, `rr`, the tag pipe, the FIFO and the accumulators. Assertion mid-operation drops all in-flight batches. Any late `tree_out_avl` from the tree is reset by the same `rst`.

## Timing
- Accept in cycle T → `tree_in_avl`=1 at T+1 → `tree_out_avl` at T+1+`TREE_LAT` → `rsp_valid` at T+2+`TREE_LAT` at the earliest (default: T+5).
- Sustained throughput is one batch per cycle while credit is available and `rsp_ready`=1.
- A pop frees credit in the following cycle; `req_ready` never depends on the same-cycle `rsp_ready`.

## Configuration
- Macro: `ADDER_TREE_SCHED_ACCUM_EN`.
- **Defined:**
  - One `RANK_FACTOR_MATRIX`×`N` accumulator per requester.
  - A result with last=0 adds into `acc[id]` lane-wise (N-bit two's complement, wrap-around). Nothing is pushed to the FIFO, and its credit is released.
  - A result with last=1 pushes `acc[id]`+`tree_c` with `rsp_last`=1 and clears `acc[id]`.
  - Latency to `rsp_valid` is unchanged; the sum is computed in the push path.
- **Undefined:** no accumulators. Every result is pushed as-is, with `rsp_last` = batch last.

## Test plan
- **Single batch, reset path.** Requester 2 sends all lanes = 1, last=1 → `tree_in_avl` one cycle after accept; `rsp_valid` 5 cycles after accept with `rsp_id`=2, every lane = 8, `rsp_last`=1.
- **Fairness.** All four requesters hold `req_valid`, `rsp_ready`=1 → grants 0,1,2,3,0,… with one grant per cycle. Responses return in grant order with matching IDs.
- **Backpressure.** `rsp_ready`=0, continuous requests → exactly 8 accepts, then `req_ready`=0. Raising `rsp_ready` for 1 cycle → one pop and one more grant the next cycle. No data loss.
- **Accumulation.** With `ADDER_TREE_SCHED_ACCUM_EN`, requester 1 sends batches with lanes = 1, 2, 3 (last on the third) → single response, every lane = 48. Without the macro → three responses: 8, 16, 24.
- **Error detection.** Inject `tree_out_avl`=1 with an empty tag pipe → `err`=1, held until `rst`=0. The FIFO does not change.
- **Reset mid-flight.** Assert `rst`=0 with 3 batches in flight and 2 in the FIFO → all outputs are 0 immediately. After release, `rr`=0, `rsp_valid`=0, and the first grant goes to the lowest-index requester.
